// File: rtl/sm_ram_pkg.sv
// Shared types, default geometry and display-plane address helpers for sm_ram_banked.
package sm_ram_pkg;

   typedef enum logic [1:0] {CLEAR, IDLE, DUMP, LOAD} ram_state_t;

   localparam int DEF_ADDR_W    = 7;
   localparam int DEF_DATA_W    = 4;
   localparam int DEF_DISP_BASE = 'h60;
   localparam int DEF_SEGS      = 16;
   localparam int DEF_PLANES    = 2;

   // Negative below the display window; callers range-check against PLANES.
   function automatic int plane_of(input int a, input int base, input int seg_sh);
      return (a - base) >>> seg_sh;
   endfunction

   function automatic int seg_of(input int a, input int base, input int segs);
      return (a - base) & (segs - 1);
   endfunction

endpackage

// File: rtl/sm_seg_cache.sv
// Write-through cache of the display planes; one flop word per segment, LCD column picked by lcd_h.
module sm_seg_cache #(
   parameter int PLANES = 2,
   parameter int SEGS   = 16,
   parameter int DATA_W = 4,
   localparam int PW    = (PLANES > 1) ? $clog2(PLANES) : 1,
   localparam int SW    = $clog2(SEGS),
   localparam int HW    = $clog2(DATA_W)
) (
   input  logic                   clk,
   input  logic                   clr,
   input  logic                   we,
   input  logic [PW-1:0]          plane,
   input  logic [SW-1:0]          seg,
   input  logic [DATA_W-1:0]      data,
   input  logic [HW-1:0]          lcd_h,
   output logic [PLANES*SEGS-1:0] segments
);

   logic [PLANES-1:0][SEGS-1:0][DATA_W-1:0] cache;

   always_ff @(posedge clk) begin
      if (clr)
         cache <= '0;
      else if (we)
         cache[plane][seg] <= data;
   end

   for (genvar p = 0; p < PLANES; p++) begin : g_plane
      for (genvar i = 0; i < SEGS; i++) begin : g_seg
         assign segments[p*SEGS+i] = cache[p][i][lcd_h];
      end
   end

endmodule

// File: rtl/sm_ram_banked.sv
// Banked internal RAM with post-reset clear, display segment caches and a savestate dump/load stream.
// Optional macro SM_RAM_SEG_BLANK_EN adds a 'blank' input that forces segments low.
module sm_ram_banked import sm_ram_pkg::*; #(
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int DATA_W    = DEF_DATA_W,
   parameter int DISP_BASE = DEF_DISP_BASE,
   parameter int SEGS      = DEF_SEGS,
   parameter int PLANES    = DEF_PLANES
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [ADDR_W-1:0]         addr,
   input  logic                      wren,
   input  logic [DATA_W-1:0]         data,
   output logic [DATA_W-1:0]         q,
   output logic                      busy,
   input  logic [$clog2(DATA_W)-1:0] lcd_h,
`ifdef SM_RAM_SEG_BLANK_EN
   input  logic                      blank,
`endif
   output logic [PLANES*SEGS-1:0]    segments,
   input  logic                      ss_dump_start,
   input  logic                      ss_load_start,
   output logic [DATA_W-1:0]         ss_out_data,
   output logic                      ss_out_valid,
   input  logic                      ss_out_ready,
   input  logic [DATA_W-1:0]         ss_in_data,
   input  logic                      ss_in_valid,
   output logic                      ss_in_ready,
   output logic                      ss_done
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam int SW    = $clog2(SEGS);
   localparam int PW    = (PLANES > 1) ? $clog2(PLANES) : 1;
   localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(DEPTH - 1);

   if (DISP_BASE + PLANES*SEGS > DEPTH) begin : g_geom_err
      $error("sm_ram_banked: display planes extend past the RAM");
   end

   ram_state_t        state;
   logic [ADDR_W:0]   ptr;
   logic [ADDR_W-1:0] ptr_lo;
   logic              last;
   logic [DATA_W-1:0] ram [DEPTH];

   logic              we, hit;
   logic [ADDR_W-1:0] wa;
   logic [DATA_W-1:0] wd;
   logic [PW-1:0]     cplane;
   logic [SW-1:0]     cseg;
   logic [PLANES*SEGS-1:0] seg_raw;

   assign ptr_lo = ptr[ADDR_W-1:0];
   assign last   = (ptr == LAST);

   // Single RAM write port shared by the clear sweep, CPU and savestate load.
   always_comb begin
      we = 1'b0;
      wa = '0;
      wd = '0;
      unique case (state)
         CLEAR: begin we = 1'b1; wa = ptr_lo; end
         IDLE:  begin we = wren; wa = addr; wd = data; end
         LOAD:  begin we = ss_in_valid && ss_in_ready; wa = ptr_lo; wd = ss_in_data; end
         default: ;
      endcase
      if (reset) we = 1'b0;
   end

   assign hit    = (int'(wa) >= DISP_BASE) && (plane_of(int'(wa), DISP_BASE, SW) < PLANES);
   assign cplane = PW'(plane_of(int'(wa), DISP_BASE, SW));
   assign cseg   = SW'(seg_of(int'(wa), DISP_BASE, SEGS));

   always_ff @(posedge clk) begin
      if (we) ram[wa] <= wd;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= CLEAR;
         ptr          <= '0;
         busy         <= 1'b1;
         q            <= '0;
         ss_out_data  <= '0;
         ss_out_valid <= 1'b0;
         ss_in_ready  <= 1'b0;
         ss_done      <= 1'b0;
      end else begin
         ss_done <= 1'b0;
         unique case (state)
            CLEAR: begin
               ptr <= ptr + 1'b1;
               if (last) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  ptr   <= '0;
               end
            end
            IDLE: begin
               q <= ram[addr];
               if (ss_dump_start) begin
                  state <= DUMP;
                  busy  <= 1'b1;
                  ptr   <= '0;
               end else if (ss_load_start) begin
                  state       <= LOAD;
                  busy        <= 1'b1;
                  ptr         <= '0;
                  ss_in_ready <= 1'b1;
               end
            end
            DUMP: begin
               // First cycle primes word 0 so a same-cycle CPU write at the start lands first.
               if (!ss_out_valid) begin
                  ss_out_data  <= ram[ptr_lo];
                  ss_out_valid <= 1'b1;
               end else if (ss_out_ready) begin
                  if (last) begin
                     ss_out_valid <= 1'b0;
                     ss_done      <= 1'b1;
                     busy         <= 1'b0;
                     state        <= IDLE;
                  end else begin
                     ptr         <= ptr + 1'b1;
                     ss_out_data <= ram[ptr_lo + 1'b1];
                  end
               end
            end
            LOAD: begin
               if (ss_in_valid && ss_in_ready) begin
                  if (last) begin
                     ss_in_ready <= 1'b0;
                     ss_done     <= 1'b1;
                     busy        <= 1'b0;
                     state       <= IDLE;
                  end else begin
                     ptr <= ptr + 1'b1;
                  end
               end
            end
            default: state <= CLEAR;
         endcase
      end
   end

   sm_seg_cache #(.PLANES(PLANES), .SEGS(SEGS), .DATA_W(DATA_W)) u_cache (
      .clk      (clk),
      .clr      (reset),
      .we       (we && hit),
      .plane    (cplane),
      .seg      (cseg),
      .data     (wd),
      .lcd_h    (lcd_h),
      .segments (seg_raw)
   );

`ifdef SM_RAM_SEG_BLANK_EN
   assign segments = blank ? '0 : seg_raw;
`else
   assign segments = seg_raw;
`endif

endmodule

// File: tb/tb_sm_ram_banked.sv
// Randomized bench for sm_ram_banked against an array-level model of RAM, caches and stream phases.
module tb_sm_ram_banked;

   localparam int DEPTH = 128;
   localparam int MC = 0, MI = 1, MD = 2, ML = 3;

   logic        clk = 1'b0;
   logic        reset;
   logic [6:0]  addr;
   logic        wren;
   logic [3:0]  data;
   logic [3:0]  q;
   logic        busy;
   logic [1:0]  lcd_h;
`ifdef SM_RAM_SEG_BLANK_EN
   logic        blank;
`endif
   logic [31:0] segments;
   logic        ss_dump_start, ss_load_start;
   logic [3:0]  ss_out_data;
   logic        ss_out_valid, ss_out_ready;
   logic [3:0]  ss_in_data;
   logic        ss_in_valid, ss_in_ready, ss_done;

   sm_ram_banked dut (
      .clk(clk), .reset(reset), .addr(addr), .wren(wren), .data(data), .q(q),
      .busy(busy), .lcd_h(lcd_h),
`ifdef SM_RAM_SEG_BLANK_EN
      .blank(blank),
`endif
      .segments(segments),
      .ss_dump_start(ss_dump_start), .ss_load_start(ss_load_start),
      .ss_out_data(ss_out_data), .ss_out_valid(ss_out_valid), .ss_out_ready(ss_out_ready),
      .ss_in_data(ss_in_data), .ss_in_valid(ss_in_valid), .ss_in_ready(ss_in_ready),
      .ss_done(ss_done)
   );

   always #5 clk = ~clk;

   int ntests = 0, nfail = 0;
   bit chk_en = 0;

   // Model state
   logic [3:0] m_ram [DEPTH];
   logic [3:0] m_cache [2][16];
   logic [3:0] m_q;
   int         m_mode, m_ptr;
   bit         m_done;
   bit         stall;
   logic [3:0] held;
   int         dump_cnt, done_cnt;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      ntests++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic wr(input int a, input logic [3:0] d);
      m_ram[a] = d;
      if (a >= 'h60 && a < 'h80) m_cache[(a - 'h60) / 16][(a - 'h60) % 16] = d;
   endtask

   function automatic logic [31:0] exp_seg();
      logic [31:0] r;
      for (int p = 0; p < 2; p++)
         for (int i = 0; i < 16; i++)
            r[p*16+i] = m_cache[p][i][lcd_h];
`ifdef SM_RAM_SEG_BLANK_EN
      if (blank) r = '0;
`endif
      return r;
   endfunction

   // Advance one clock; the model applies the same edge using the pre-edge inputs.
   task automatic tick();
      logic       ov, ordy;
      logic [3:0] od;
      ov = ss_out_valid; ordy = ss_out_ready; od = ss_out_data;
      @(posedge clk);
      m_done = 0;
      if (reset) begin
         m_mode = MC; m_ptr = 0; m_q = '0;
         for (int p = 0; p < 2; p++)
            for (int i = 0; i < 16; i++) m_cache[p][i] = '0;
      end else begin
         case (m_mode)
            MC: begin
               wr(m_ptr, 4'h0);
               if (m_ptr == DEPTH-1) begin m_mode = MI; m_ptr = 0; end
               else m_ptr++;
            end
            MI: begin
               m_q = m_ram[addr];
               if (wren) wr(int'(addr), data);
               if (ss_dump_start) begin m_mode = MD; m_ptr = 0; stall = 0; end
               else if (ss_load_start) begin m_mode = ML; m_ptr = 0; end
            end
            MD: if (ov) begin
               if (stall) chk("dump_stable", od, held);
               if (ordy) begin
                  chk("dump_word", od, m_ram[m_ptr]);
                  dump_cnt++;
                  stall = 0;
                  if (m_ptr == DEPTH-1) begin m_mode = MI; m_done = 1; end
                  else m_ptr++;
               end else begin
                  stall = 1; held = od;
               end
            end
            ML: if (ss_in_valid) begin
               wr(m_ptr, ss_in_data);
               if (m_ptr == DEPTH-1) begin m_mode = MI; m_done = 1; end
               else m_ptr++;
            end
            default: ;
         endcase
      end
      #1;
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("q", q, m_q);
         chk("segments", segments, exp_seg());
         chk("busy", busy, m_mode != MI);
         chk("ss_in_ready", ss_in_ready, m_mode == ML);
         chk("ss_done", ss_done, m_done);
         if (ss_done) done_cnt++;
      end
   end

   task automatic busy_count(input string name);
      int n = 0;
      while (busy && n < 300) begin tick(); n++; end
      chk(name, n, 128);
   endtask

   task automatic random_idle(input int cycles);
      for (int k = 0; k < cycles; k++) begin
         addr  = ($urandom % 2) ? 7'(7'h58 + $urandom_range(0, 39)) : 7'($urandom);
         wren  = 1'($urandom);
         data  = 4'($urandom);
         lcd_h = 2'($urandom);
         tick();
      end
      wren = 0;
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      int n;
      reset = 1; addr = 0; wren = 0; data = 0; lcd_h = 0;
      ss_dump_start = 0; ss_load_start = 0; ss_out_ready = 0;
      ss_in_data = 0; ss_in_valid = 0;
      dump_cnt = 0; done_cnt = 0; stall = 0; held = 0; m_done = 0;
`ifdef SM_RAM_SEG_BLANK_EN
      blank = 0;
`endif
      tick();
      chk_en = 1;
      tick();
      chk("reset_q", q, 4'h0);
      chk("reset_segments", segments, 32'h0);
      chk("reset_busy", busy, 1'b1);
      reset = 0;
      busy_count("clear_busy_cycles");

      addr = 7'h05; tick();
      chk("read_05", q, 4'h0);
      chk("segments_after_clear", segments, 32'h0);

      addr = 7'h61; data = 4'b0101; wren = 1; tick();
      addr = 7'h72; data = 4'b0011; tick();
      wren = 0;
      lcd_h = 0; #1; chk("h0_seg1", segments[1], 1'b1); chk("h0_seg18", segments[18], 1'b1);
      lcd_h = 1; #1; chk("h1_seg1", segments[1], 1'b0); chk("h1_seg18", segments[18], 1'b1);
      lcd_h = 2; #1; chk("h2_seg1", segments[1], 1'b1); chk("h2_seg18", segments[18], 1'b0);

      addr = 7'h10; data = 4'h9; wren = 1; tick();
      chk("rbw_old", q, 4'h0);
      wren = 0; tick();
      chk("rbw_new", q, 4'h9);

      random_idle(300);

      // Dump: both starts together (dump wins), with a CPU write in the start cycle.
      addr = 7'h33; data = 4'($urandom); wren = 1;
      ss_dump_start = 1; ss_load_start = 1; tick();
      ss_dump_start = 0; ss_load_start = 0;
      dump_cnt = 0; done_cnt = 0; n = 0;
      while (m_mode == MD && n < 2000) begin
         ss_out_ready = ~ss_out_ready;
         wren = 1'($urandom); addr = 7'($urandom); data = 4'($urandom);
         ss_load_start = 1'($urandom_range(0, 15) == 0);
         tick(); n++;
      end
      wren = 0; ss_load_start = 0; ss_out_ready = 0;
      chk("dump_timeout", n < 2000, 1'b1);
      tick();
      chk("dump_words", dump_cnt, 128);
      chk("dump_done_pulses", done_cnt, 1);
      chk("dump_valid_low", ss_out_valid, 1'b0);

      // Read everything back: writes attempted during the dump must not have landed.
      for (int a = 0; a < DEPTH; a++) begin addr = 7'(a); tick(); end

      // Full load, value = addr[3:0].
      ss_load_start = 1; tick(); ss_load_start = 0;
      done_cnt = 0; n = 0;
      while (m_mode == ML && n < 2000) begin
         ss_in_valid = ($urandom_range(0, 3) != 0);
         ss_in_data  = 4'(m_ptr);
         wren = 1'($urandom); addr = 7'($urandom); data = 4'($urandom);
         tick(); n++;
      end
      ss_in_valid = 0; wren = 0;
      chk("load_timeout", n < 2000, 1'b1);
      tick();
      chk("load_done_pulses", done_cnt, 1);
      addr = 7'h65; tick();
      chk("load_read_65", q, 4'h5);
      lcd_h = 0; #1; chk("load_seg5_h0", segments[5], 1'b1); chk("load_seg21_h0", segments[21], 1'b1);
      lcd_h = 1; #1; chk("load_seg5_h1", segments[5], 1'b0);

      // Load aborted by reset at word 40.
      ss_load_start = 1; tick(); ss_load_start = 0;
      done_cnt = 0; n = 0;
      while (m_ptr < 40 && n < 500) begin
         ss_in_valid = 1'($urandom);
         ss_in_data  = 4'(m_ptr);
         tick(); n++;
      end
      ss_in_valid = 0;
      reset = 1; tick(); reset = 0;
      busy_count("abort_clear_busy_cycles");
      chk("abort_no_done", done_cnt, 0);
      addr = 7'h65; tick();
      chk("abort_read_65", q, 4'h0);

      random_idle(200);

`ifdef SM_RAM_SEG_BLANK_EN
      addr = 7'h60; data = 4'hF; wren = 1; tick(); wren = 0;
      blank = 1; #1; chk("blank_on", segments, 32'h0);
      tick();
      blank = 0; #1; chk("blank_off_seg0", segments[0], 1'b1);
      tick();
`endif

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
